id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the EX-stage ALU.
- Captures decoded instruction fields from ID and applies EX/MEM and MEM/WB forwarding to register operands.
- Drives the ALU's alu_a, alu_b and alu_op, plus the control fields that travel on to EX/MEM.
- Detects load-use hazards so the hazard controller can stall IF/ID and the PC.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.
- OP_W, 4, ALU opcode width. 0 means NOP; 1..12 cover ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRA, SRL, LUI.

Ports:
- clk in 1: single clock; all state updates on rising edge.
- rst in 1: synchronous, active-high reset.
- stall in 1: hold current ID/EX contents.
- flush in 1: load a bubble.
- id_valid in 1: ID slot holds a real instruction.
- id_alu_op in OP_W: decoded ALU opcode.
- id_rs_data, id_rt_data in DATA_W: register-file read data.
- id_imm in DATA_W: immediate, already sign- or zero-extended by the decoder.
- id_shamt in 5: shift amount field.
- id_rs, id_rt, id_rd in REG_AW: source and destination register indices.
- id_sel_imm in 1: alu_b takes the immediate.
- id_sel_shamt in 1: alu_a takes the zero-extended shamt.
- id_reg_write, id_mem_read, id_mem_write in 1: control bits.
- exm_reg_write in 1, exm_rd in REG_AW, exm_result in DATA_W: EX/MEM forwarding source.
- mwb_reg_write in 1, mwb_rd in REG_AW, mwb_result in DATA_W: MEM/WB forwarding source.
- ex_valid out 1: EX slot holds a real instruction.
- alu_a, alu_b out DATA_W: ALU operands.
- alu_op out OP_W: ALU opcode.
- ex_store_data out DATA_W: forwarded rt value for stores.
- ex_rd out REG_AW: destination register index.
- ex_reg_write, ex_mem_read, ex_mem_write out 1: control bits passed to EX/MEM.
- load_use_hazard out 1: load-use hazard detected.

Behaviour:
- Registered fields: valid, alu_op, rs_data, rt_data, imm, shamt, rs, rt, rd, sel_imm, sel_shamt, reg_write, mem_read, mem_write.
- Per-edge priority is rst > flush > stall > load.
  - rst or flush: every registered field is cleared to 0, i.e. a bubble with alu_op=NOP and all controls 0.
  - stall: all registers keep their value.
  - Otherwise: all fields load from id_*. Control bits load ANDed with id_valid.
- Latency: an ID instruction appears on the ALU outputs one cycle after capture. Operand forwarding is combinational within the EX cycle.
- Forwarding (combinational, per source s in {rs, rt}):
  - If exm_reg_write, exm_rd!=0 and exm_rd==s, use exm_result.
  - Else if mwb_reg_write, mwb_rd!=0 and mwb_rd==s, use mwb_result.
  - Else use the registered data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- alu_a = sel_shamt ? {27'b0, shamt} : fwd_rs.
- alu_b = sel_imm ? imm : fwd_rt.
- ex_store_data = fwd_rt, regardless of sel_imm.
- Shift ops set sel_shamt for the constant form and take the shift amount from alu_a[4:0]. Variable shifts leave sel_shamt=0, so alu_a = fwd_rs.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt). Purely combinational.
  - The hazard controller responds with flush on this stage and a stall upstream.
  - The following cycle the load sits in MEM/WB and forwarding resolves the dependency.
- stall and flush together: flush wins and a bubble is inserted.
- Reset mid-operation: contents are lost and no partial state is retained.
- Reset output values: all outputs 0, except that alu_a and alu_b equal any active forwarding values.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - fwd_rs and fwd_rt are the registered data; exm_* and mwb_* are ignored.
  - load_use_hazard widens to any ex_valid & ex_reg_write & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt), so the hazard controller serialises all RAW hazards.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode constants A_NOP..A_LUI (4-bit, values 0..12);
  - DATA_W and REG_AW;
  - a struct/typedef for the ID/EX control bundle (alu_op, sel_imm, sel_shamt, reg_write, mem_read, mem_write).
- One natural sub-module, fwd_mux, instantiated twice (rs, rt):
  - inputs: index, registered data, exm_* and mwb_*;
  - output: the forwarded value.

Test Plan:
- Reset/bubble: assert rst with id_valid=1 and id_alu_op=ADD. Next cycle ex_valid=0, alu_op=0, all controls 0. Same result with flush=1 and stall=1 together.
- Plain capture: id_rs_data=5, id_imm=0xFFFFFFFC, sel_imm=1, op=ADD, no forwarding matches. Next cycle alu_a=5, alu_b=0xFFFFFFFC, alu_op=1.
- Forward priority: EX has rs=3 and rs_data=1, with exm_rd=3/exm_result=0x11 and mwb_rd=3/mwb_result=0x22, both writing. Expect alu_a=0x11. Drop exm_reg_write and expect 0x22. Set rs=0 with matching rd=0 and expect registered 1.
- Stall hold: load op=SUB, then assert stall for 3 cycles while id_* changes. alu_op stays 2 and ex_rd is unchanged throughout.
- Load-use: EX holds mem_read=1, ex_rd=8; ID presents id_rt=8. load_use_hazard=1. With id_rt=9 and id_rs=0 it is 0. With ex_rd=0 it is 0.
- Shift/store operands: sel_shamt=1, shamt=4, op=SLL, rt_data=0x1 gives alu_a=4, alu_b=1. A store with sel_imm=1 and mwb forwarding rt to 0xABCD gives ex_store_data=0xABCD and alu_b=imm.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and the ID/EX control bundle.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] A_NOP  = 4'd0;
  localparam logic [OP_W-1:0] A_ADD  = 4'd1;
  localparam logic [OP_W-1:0] A_SUB  = 4'd2;
  localparam logic [OP_W-1:0] A_AND  = 4'd3;
  localparam logic [OP_W-1:0] A_OR   = 4'd4;
  localparam logic [OP_W-1:0] A_XOR  = 4'd5;
  localparam logic [OP_W-1:0] A_NOR  = 4'd6;
  localparam logic [OP_W-1:0] A_SLT  = 4'd7;
  localparam logic [OP_W-1:0] A_SLTU = 4'd8;
  localparam logic [OP_W-1:0] A_SLL  = 4'd9;
  localparam logic [OP_W-1:0] A_SRA  = 4'd10;
  localparam logic [OP_W-1:0] A_SRL  = 4'd11;
  localparam logic [OP_W-1:0] A_LUI  = 4'd12;

  typedef struct packed {
    logic [OP_W-1:0] alu_op;
    logic            sel_imm;
    logic            sel_shamt;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: EX/MEM beats MEM/WB, register 0 never forwards.
// Forwarding is compiled in only when ID_EX_FORWARD_EN is defined.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exm_reg_write_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [DATA_W-1:0] exm_result_i,
  input  logic              mwb_reg_write_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic [DATA_W-1:0] mwb_result_i,
  output logic [DATA_W-1:0] fwd_o
);

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    fwd_o = reg_data_i;
    if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == idx_i)) begin
      fwd_o = exm_result_i;
    end else if (mwb_reg_write_i && (mwb_rd_i != '0) && (mwb_rd_i == idx_i)) begin
      fwd_o = mwb_result_i;
    end
  end
`else
  // Without forwarding the hazard unit serialises RAW pairs, so these are dead.
  logic unused_fwd;
  assign unused_fwd = ^{idx_i, exm_reg_write_i, exm_rd_i, exm_result_i,
                        mwb_reg_write_i, mwb_rd_i, mwb_result_i};
  assign fwd_o = reg_data_i;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU operand selection and load-use detection.
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_operand_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int OP_W   = cpu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_sel_imm,
  input  logic              id_sel_shamt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_hazard
);
  import cpu_pkg::id_ex_ctrl_t;

  id_ex_ctrl_t       ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] rs_data_d, rs_data_q;
  logic [DATA_W-1:0] rt_data_d, rt_data_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  logic [4:0]        shamt_d, shamt_q;
  logic [REG_AW-1:0] rs_d, rs_q;
  logic [REG_AW-1:0] rt_d, rt_q;
  logic [REG_AW-1:0] rd_d, rd_q;

  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic              hazard_src;

  // flush beats stall; rst is applied in the register process above both.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (flush) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      shamt_d   = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else if (!stall) begin
      valid_d          = id_valid;
      ctrl_d.alu_op    = id_alu_op;
      ctrl_d.sel_imm   = id_sel_imm;
      ctrl_d.sel_shamt = id_sel_shamt;
      ctrl_d.reg_write = id_reg_write & id_valid;
      ctrl_d.mem_read  = id_mem_read & id_valid;
      ctrl_d.mem_write = id_mem_write & id_valid;
      rs_data_d        = id_rs_data;
      rt_data_d        = id_rt_data;
      imm_d            = id_imm;
      shamt_d          = id_shamt;
      rs_d             = id_rs;
      rt_d             = id_rt;
      rd_d             = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx_i(rs_q), .reg_data_i(rs_data_q),
    .exm_reg_write_i(exm_reg_write), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .mwb_reg_write_i(mwb_reg_write), .mwb_rd_i(mwb_rd), .mwb_result_i(mwb_result),
    .fwd_o(fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx_i(rt_q), .reg_data_i(rt_data_q),
    .exm_reg_write_i(exm_reg_write), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .mwb_reg_write_i(mwb_reg_write), .mwb_rd_i(mwb_rd), .mwb_result_i(mwb_result),
    .fwd_o(fwd_rt)
  );

  assign alu_a         = ctrl_q.sel_shamt ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
  assign alu_b         = ctrl_q.sel_imm ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign alu_op        = ctrl_q.alu_op;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;

  // Without forwarding every in-flight writer is a hazard, not just loads.
`ifdef ID_EX_FORWARD_EN
  assign hazard_src = ctrl_q.mem_read;
`else
  assign hazard_src = ctrl_q.reg_write;
`endif

  assign load_use_hazard = valid_q & hazard_src & (rd_q != '0) & id_valid &
                           ((rd_q == id_rs) | (rd_q == id_rt));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus short random bench for id_ex_operand_stage with an expected-output queue.
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int VW = 1 + 32 + 32 + 4 + 32 + 5 + 4;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [3:0]  id_alu_op;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic        id_sel_imm, id_sel_shamt, id_reg_write, id_mem_read, id_mem_write;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;

  // Bench-side view of the stage contents
  logic        m_valid, m_sel_imm, m_sel_shamt, m_rw, m_mr, m_mw;
  logic [3:0]  m_op;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_shamt, m_rs, m_rt, m_rd;

  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_sel_imm(id_sel_imm), .id_sel_shamt(id_sel_shamt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_hazard(load_use_hazard)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
    if (FWD_EN && exm_reg_write && exm_rd != 5'd0 && exm_rd == idx) return exm_result;
    if (FWD_EN && mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == idx) return mwb_result;
    return d;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [31:0] ea, eb, es;
    logic        eh;
    es = fwd(m_rt, m_rt_data);
    ea = m_sel_shamt ? {27'b0, m_shamt} : fwd(m_rs, m_rs_data);
    eb = m_sel_imm ? m_imm : es;
    eh = m_valid & (FWD_EN ? m_mr : m_rw) & (m_rd != 5'd0) & id_valid &
         ((m_rd == id_rs) | (m_rd == id_rt));
    return {m_valid, ea, eb, m_op, es, m_rd, m_rw, m_mr, m_mw, eh};
  endfunction

  task automatic clear_model();
    m_valid = 0; m_op = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_shamt = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_sel_imm = 0; m_sel_shamt = 0;
    m_rw = 0; m_mr = 0; m_mw = 0;
  endtask

  // One clock: the model captures at the rising edge, inputs change after the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst || flush) clear_model();
    else if (!stall) begin
      m_valid = id_valid; m_op = id_alu_op; m_rs_data = id_rs_data; m_rt_data = id_rt_data;
      m_imm = id_imm; m_shamt = id_shamt; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_sel_imm = id_sel_imm; m_sel_shamt = id_sel_shamt;
      m_rw = id_reg_write & id_valid; m_mr = id_mem_read & id_valid;
      m_mw = id_mem_write & id_valid;
    end
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectation queued with the current stimulus, popped once outputs settle.
  task automatic sample(input string tag);
    logic [VW-1:0] obs, e;
    exp_q.push_back(exp_vec());
    #1;
    obs = {ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard};
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic id_clear();
    id_valid = 0; id_alu_op = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_sel_imm = 0; id_sel_shamt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    id_clear();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    clear_model();
    @(negedge clk);
    cycle();

    // Reset with a real instruction presented
    id_valid = 1; id_alu_op = A_ADD; id_reg_write = 1; id_rd = 5'd6;
    cycle();
    sample("reset_bubble");
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_alu_op", {28'b0, alu_op}, 32'd0);

    // flush and stall together still inserts a bubble
    rst = 0; id_alu_op = A_ADD; id_rd = 5'd6;
    cycle();
    flush = 1; stall = 1;
    cycle();
    sample("flush_stall_bubble");
    chk("flush_stall_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_stall_reg_write", {31'b0, ex_reg_write}, 32'd0);
    flush = 0; stall = 0;

    // Plain capture with immediate operand
    id_valid = 1; id_alu_op = A_ADD; id_rs_data = 32'd5; id_imm = 32'hFFFF_FFFC;
    id_sel_imm = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_write = 1;
    cycle();
    sample("plain_capture");
    chk("plain_alu_a", alu_a, 32'd5);
    chk("plain_alu_b", alu_b, 32'hFFFF_FFFC);
    chk("plain_alu_op", {28'b0, alu_op}, 32'd1);

    // Forwarding priority on rs
    id_sel_imm = 0; id_rs = 5'd3; id_rs_data = 32'd1; id_rd = 5'd4;
    cycle();
    exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd = 5'd3; mwb_result = 32'h22;
    sample("fwd_both");
    chk("fwd_exm_wins", alu_a, FWD_EN ? 32'h11 : 32'd1);
    exm_reg_write = 0;
    sample("fwd_mwb_only");
    chk("fwd_mwb", alu_a, FWD_EN ? 32'h22 : 32'd1);
    exm_reg_write = 1;
    id_rs = 5'd0; id_rs_data = 32'd1; exm_rd = 5'd0; mwb_rd = 5'd0;
    cycle();
    sample("fwd_reg0");
    chk("fwd_reg0_alu_a", alu_a, 32'd1);
    exm_reg_write = 0; mwb_reg_write = 0;

    // Stall hold across changing ID inputs
    id_alu_op = A_SUB; id_rd = 5'd7; id_valid = 1;
    cycle();
    sample("stall_load");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_alu_op = 4'($urandom_range(0, 12)); id_rd = 5'($urandom_range(0, 31));
      id_rs_data = $urandom; id_valid = 1'($urandom_range(0, 1));
      cycle();
      sample("stall_hold");
      chk("stall_alu_op", {28'b0, alu_op}, 32'd2);
      chk("stall_ex_rd", {27'b0, ex_rd}, 32'd7);
    end
    stall = 0;

    // Load-use detection
    id_clear();
    id_valid = 1; id_alu_op = A_ADD; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd8;
    cycle();
    id_mem_read = 0; id_reg_write = 0; id_rd = 5'd0; id_rs = 5'd1; id_rt = 5'd8;
    sample("lu_hit");
    chk("lu_hit_flag", {31'b0, load_use_hazard}, 32'd1);
    id_rt = 5'd9; id_rs = 5'd0;
    sample("lu_miss");
    chk("lu_miss_flag", {31'b0, load_use_hazard}, 32'd0);
    id_mem_read = 1; id_reg_write = 1; id_rd = 5'd0;
    cycle();
    id_rt = 5'd0; id_rs = 5'd0;
    sample("lu_rd0");
    chk("lu_rd0_flag", {31'b0, load_use_hazard}, 32'd0);
    id_mem_read = 0; id_reg_write = 1; id_rd = 5'd8;
    cycle();
    id_reg_write = 0; id_rt = 5'd8;
    sample("raw_alu_writer");
    chk("raw_alu_flag", {31'b0, load_use_hazard}, FWD_EN ? 32'd0 : 32'd1);

    // Constant shift then forwarded store
    id_clear();
    id_valid = 1; id_alu_op = A_SLL; id_sel_shamt = 1; id_shamt = 5'd4;
    id_rs_data = 32'h55; id_rt_data = 32'h1; id_rt = 5'd2; id_reg_write = 1; id_rd = 5'd3;
    cycle();
    sample("shift_const");
    chk("shift_alu_a", alu_a, 32'd4);
    chk("shift_alu_b", alu_b, 32'd1);
    id_clear();
    id_valid = 1; id_alu_op = A_ADD; id_sel_imm = 1; id_imm = 32'h10; id_rt = 5'd5;
    id_rt_data = 32'h1234; id_mem_write = 1;
    cycle();
    mwb_reg_write = 1; mwb_rd = 5'd5; mwb_result = 32'hABCD;
    sample("store_fwd");
    chk("store_data", ex_store_data, FWD_EN ? 32'hABCD : 32'h1234);
    chk("store_alu_b", alu_b, 32'h10);
    mwb_reg_write = 0;

    // Invalid ID slot must not carry controls
    id_valid = 0; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
    cycle();
    sample("invalid_ctrl");
    chk("invalid_reg_write", {31'b0, ex_reg_write}, 32'd0);

    // Random traffic with small register indices to provoke forwarding and hazards
    for (int i = 0; i < 40; i++) begin
      rst = ($urandom_range(0, 19) == 0); flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 4) == 0); id_valid = 1'($urandom_range(0, 1));
      id_alu_op = 4'($urandom_range(0, 12)); id_rs_data = $urandom; id_rt_data = $urandom;
      id_imm = $urandom; id_shamt = 5'($urandom_range(0, 31));
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_sel_imm = 1'($urandom_range(0, 1));
      id_sel_shamt = 1'($urandom_range(0, 1)); id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read = 1'($urandom_range(0, 1)); id_mem_write = 1'($urandom_range(0, 1));
      cycle();
      rst = 0; flush = 0; stall = 0;
      exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3));
      exm_result = $urandom; mwb_reg_write = 1'($urandom_range(0, 1));
      mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      sample("random");
    end

    // Reset mid-operation drops everything
    exm_reg_write = 0; mwb_reg_write = 0;
    id_valid = 1; id_alu_op = A_XOR; id_reg_write = 1; id_rd = 5'd9;
    cycle();
    rst = 1;
    cycle();
    sample("reset_mid_op");
    chk("reset_mid_ex_rd", {27'b0, ex_rd}, 32'd0);
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
